// File: rtl/i3c_pkg.sv
// Shared I3C bus types: per-line filtered state and the bus state consumed by the protocol FSMs.
// Combinational types only; no latency, no backpressure.
package i3c_pkg;

  localparam logic BusLineIdle = 1'b1;

  typedef struct packed {
    logic value;
    logic pos_edge;
    logic neg_edge;
    logic stable_high;
    logic stable_low;
  } signal_state_t;

  typedef struct packed {
    signal_state_t sda;
    signal_state_t scl;
    logic          start_det;
    logic          rstart_det;
    logic          stop_det;
  } bus_state_t;

endpackage

// File: rtl/i3c_line_filter.sv
// One bus line: 2-flop synchronizer, glitch filter, edge pulses and saturating stable counter.
// Raw pin to filtered value in 3 + filt_cycles_i clocks; no backpressure (free-running sampler).
module i3c_line_filter
  import i3c_pkg::*;
#(
  parameter int FiltWidth = 4,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 line_i,
  input  logic [FiltWidth-1:0] filt_cycles_i,
  input  logic [CntWidth-1:0]  stable_cycles_i,
  output signal_state_t        state_o
);

  logic                 s1, s2;
  logic                 value;
  logic                 pos_edge, neg_edge;
  logic [FiltWidth-1:0] fcnt;
  logic [CntWidth-1:0]  scnt;
  logic                 flip;

  // The synchronized sample has disagreed for filt_cycles_i + 1 consecutive cycles.
  assign flip = (s2 != value) && (fcnt == filt_cycles_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1       <= BusLineIdle;
      s2       <= BusLineIdle;
      value    <= BusLineIdle;
      fcnt     <= '0;
      scnt     <= '0;
      pos_edge <= 1'b0;
      neg_edge <= 1'b0;
    end else begin
      s1       <= line_i;
      s2       <= s1;
      pos_edge <= flip & s2;
      neg_edge <= flip & ~s2;
      if (s2 == value) begin
        fcnt <= '0;
      end else if (flip) begin
        value <= s2;
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
      if (flip) begin
        scnt <= '0;
      end else if (scnt != '1) begin
        scnt <= scnt + 1'b1;
      end
    end
  end

  assign state_o.value       = value;
  assign state_o.pos_edge    = pos_edge;
  assign state_o.neg_edge    = neg_edge;
  assign state_o.stable_high = value & (scnt >= stable_cycles_i);
  assign state_o.stable_low  = ~value & (scnt >= stable_cycles_i);

endmodule

// File: rtl/i3c_bus_line_tracker.sv
// Filters SCL/SDA and reports START / Repeated START / STOP plus bus-busy to the protocol FSMs.
// Conditions appear in the cycle of the filtered SDA edge; busy follows one cycle later; no backpressure.
module i3c_bus_line_tracker
  import i3c_pkg::*;
#(
  parameter int FiltWidth = 4,
  parameter int CntWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 scl_i,
  input  logic                 sda_i,
  input  logic [FiltWidth-1:0] filt_cycles_i,
  input  logic [CntWidth-1:0]  stable_cycles_i,
  output bus_state_t           bus_state_o,
  output logic                 bus_busy_o
);

  signal_state_t scl, sda;
  logic          scl_quiet;
  logic          start_cond, stop_cond;
  logic          bus_busy_q;

  i3c_line_filter #(.FiltWidth(FiltWidth), .CntWidth(CntWidth)) u_scl_filter (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .line_i         (scl_i),
    .filt_cycles_i  (filt_cycles_i),
    .stable_cycles_i(stable_cycles_i),
    .state_o        (scl)
  );

  i3c_line_filter #(.FiltWidth(FiltWidth), .CntWidth(CntWidth)) u_sda_filter (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .line_i         (sda_i),
    .filt_cycles_i  (filt_cycles_i),
    .stable_cycles_i(stable_cycles_i),
    .state_o        (sda)
  );

  // SCL must be settled high and not moving in this cycle for an SDA edge to count.
  assign scl_quiet  = scl.value & scl.stable_high & ~scl.pos_edge & ~scl.neg_edge;
  assign start_cond = enable_i & sda.neg_edge & scl_quiet;
  assign stop_cond  = enable_i & sda.pos_edge & scl_quiet;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bus_busy_q <= 1'b0;
    end else if (!enable_i) begin
      bus_busy_q <= 1'b0;
    end else if (start_cond & ~bus_busy_q) begin
      bus_busy_q <= 1'b1;
    end else if (stop_cond) begin
      bus_busy_q <= 1'b0;
    end
  end

  assign bus_state_o.sda        = sda;
  assign bus_state_o.scl        = scl;
  assign bus_state_o.start_det  = start_cond & ~bus_busy_q;
  assign bus_state_o.rstart_det = start_cond & bus_busy_q;
  assign bus_state_o.stop_det   = stop_cond;
  assign bus_busy_o             = bus_busy_q;

endmodule

// File: doc/i3c_bus_line_tracker.md
Name: i3c_bus_line_tracker

Overview:
Front-end stage that samples the raw SCL/SDA pins and produces the `bus_state_t` consumed by the I3C/I2C controller and target FSMs.
- Synchronizes both lines and glitch-filters each one.
- Produces per-line edge pulses and stable-level flags.
- Detects START, Repeated START and STOP, and tracks bus-busy.
- Sits directly between the pad/IO layer and all protocol FSMs.

Parameters:
- FiltWidth, 4: width of the glitch-filter threshold and its counter.
- CntWidth, 8: width of the stable-level threshold and the per-line saturating stable counter.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- enable_i  in  1  enables condition detection and busy tracking.
- scl_i  in  1  raw SCL from the pad (asynchronous).
- sda_i  in  1  raw SDA from the pad (asynchronous).
- filt_cycles_i  in  FiltWidth  glitch rejection length N, in clk cycles.
- stable_cycles_i  in  CntWidth  cycles without a change required for stable_high/stable_low (M).
- bus_state_o  out  $bits(bus_state_t)  i3c_pkg::bus_state_t {sda, scl, start_det, rstart_det, stop_det}.
- bus_busy_o  out  1  high between a detected START and the next STOP.

Behaviour:
- Reset values:
  - Synchronizer flops = 1.
  - Filtered values = 1.
  - Filter and stable counters = 0.
  - pos_edge, neg_edge, start_det, rstart_det, stop_det = 0.
  - bus_busy_o = 0.
  - stable_high after reset is (stable_cycles_i == 0); stable_low = 0.
- Synchronizer: 2-flop per line; s2 is the synchronized sample.
- Glitch filter (per line):
  - While s2 != value: fcnt increments each cycle.
  - When s2 != value and fcnt == filt_cycles_i: value <= s2 and fcnt <= 0.
  - When s2 == value: fcnt <= 0.
  - Any bounce back before the threshold restarts the count.
  - Latency from a raw pin change to `value` = 3 + N cycles. With N = 0 it is 3 cycles.
- Edge pulses:
  - pos_edge and neg_edge are registered and high for exactly one cycle.
  - That cycle is the first one in which `value` shows the new level.
- Stable counter (per line):
  - scnt <= 0 on the cycle `value` changes; otherwise it increments, saturating at all-ones.
  - stable_high = value & (scnt >= stable_cycles_i); stable_low = ~value & (scnt >= stable_cycles_i). Both are combinational from registers.
  - stable_cycles_i is sampled live. Changing it mid-operation takes effect immediately.
- Conditions (combinational from registered state, asserted in the same cycle as the SDA edge pulse, zero when enable_i = 0):
  - Base condition C requires all of:
    - sda.neg_edge;
    - scl.value = 1;
    - scl.stable_high = 1;
    - scl.pos_edge = 0 and scl.neg_edge = 0.
  - start_det = C & ~bus_busy_o.
  - rstart_det = C & bus_busy_o.
  - stop_det = sda.pos_edge & scl.value & scl.stable_high & ~scl.pos_edge & ~scl.neg_edge.
  - SDA and SCL edges in the same cycle: no condition is reported.
  - SDA edge while SCL is high but not yet stable: no condition is reported.
- Busy register:
  - Set the cycle after start_det.
  - Cleared the cycle after stop_det.
  - Cleared (and held clear) while enable_i = 0.
  - rstart_det leaves busy set.
- enable_i = 0 affects only detection and busy. Synchronizer, filter, edges and stable flags keep tracking the pins.
- Asynchronous reset mid-transfer returns every output to its reset value immediately. The first START after release is reported as start_det, not rstart_det.

Decomposition:
- `signal_state_t` and `bus_state_t` come from i3c_pkg. No new package types.
- Add a package constant `BusLineIdle = 1'b1` for the synchronizer and filter reset value.
- One sub-module, i3c_line_filter, instantiated twice (SCL, SDA). It contains:
  - synchronizer;
  - glitch filter;
  - edge registers;
  - stable counter.
- The top level holds condition detection and the busy register.

Test Plan:
- Reset check: assert rst_ni low with pins at 1 and stable_cycles_i = 4 → value = 1, edges = 0, stable_high = 0, busy = 0. After 4 cycles: stable_high = 1.
- START/STOP: N = 2, M = 4, SCL held high for 10 cycles, drop SDA → sda.neg_edge and start_det at raw+5 cycles, busy = 1 the next cycle. Raise SDA later with SCL high and stable → stop_det on the edge cycle, busy = 0 the next cycle.
- Repeated START: after a START, toggle SCL; with SDA high, hold SCL high for 6 cycles, then drop SDA → rstart_det = 1, start_det = 0, busy stays 1.
- Glitch: N = 3, 2-cycle low pulse on SDA → value stays 1, no edges, no conditions. A 4-cycle low pulse → neg_edge at raw+6 cycles.
- Simultaneous and unstable cases:
  - Raw SDA and SCL falling on the same clock → both neg_edges in one cycle, start_det = 0.
  - SDA falls 2 cycles after SCL rises, with M = 4 → no start_det.
- Enable: enable_i = 0 during a valid START pattern → edges reported, start_det = 0, busy = 0. Reset asserted while busy → busy = 0 asynchronously.
